// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter: alternating-priority arbiter of IFU and LSU requests onto one shared
// memory port, one transaction outstanding, with a response timeout while waiting.
module mem_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  input  logic [31:0] ifu_addr,
  output logic        ifu_req_ready,
  output logic        ifu_rsp_valid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_rsp_err,
  input  logic        lsu_req_valid,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_req_ready,
  output logic        lsu_rsp_valid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_rsp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic       OWNER_IFU = 1'b0;
  localparam logic       OWNER_LSU = 1'b1;
  localparam logic [7:0] LAST_WAIT = TIMEOUT - 8'd1;

  state_t     state;
  logic       owner;
  logic       last_grant;
  logic [7:0] wait_cnt;
  logic       grant_ifu;
  logic       grant_lsu;
  logic       finish;

  // On a tie the requester that was not served last wins.
  assign grant_ifu = rst && (state == IDLE) && ifu_req_valid &&
                     (!lsu_req_valid || (last_grant == OWNER_LSU));
  assign grant_lsu = rst && (state == IDLE) && lsu_req_valid &&
                     (!ifu_req_valid || (last_grant == OWNER_IFU));

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;

  assign finish = mem_rsp_valid || (wait_cnt == LAST_WAIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      owner         <= OWNER_IFU;
      last_grant    <= OWNER_LSU;
      wait_cnt      <= 8'd0;
      mem_req_valid <= 1'b0;
      mem_addr      <= 32'h0;
      mem_wen       <= 1'b0;
      mem_wdata     <= 32'h0;
      mem_wmask     <= 4'h0;
      ifu_rsp_valid <= 1'b0;
      ifu_rdata     <= 32'h0;
      ifu_rsp_err   <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      lsu_rdata     <= 32'h0;
      lsu_rsp_err   <= 1'b0;
    end else begin
      ifu_rsp_valid <= 1'b0;
      ifu_rsp_err   <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      lsu_rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ifu) begin
            owner         <= OWNER_IFU;
            last_grant    <= OWNER_IFU;
            mem_req_valid <= 1'b1;
            mem_addr      <= ifu_addr;
            mem_wen       <= 1'b0;
            mem_wdata     <= 32'h0;
            mem_wmask     <= 4'h0;
            state         <= REQ;
          end else if (grant_lsu) begin
            owner         <= OWNER_LSU;
            last_grant    <= OWNER_LSU;
            mem_req_valid <= 1'b1;
            mem_addr      <= lsu_addr;
            mem_wen       <= lsu_wen;
            mem_wdata     <= lsu_wdata;
            mem_wmask     <= lsu_wmask;
            state         <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            wait_cnt      <= 8'd0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          // A real response in the final wait cycle beats the timeout.
          if (finish) begin
            state <= IDLE;
            if (owner == OWNER_IFU) begin
              ifu_rsp_valid <= 1'b1;
              ifu_rdata     <= mem_rsp_valid ? mem_rdata : 32'h0;
              ifu_rsp_err   <= !mem_rsp_valid;
            end else begin
              lsu_rsp_valid <= 1'b1;
              lsu_rdata     <= mem_rsp_valid ? mem_rdata : 32'h0;
              lsu_rsp_err   <= !mem_rsp_valid;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// Directed bench for mem_arbiter: a transaction-level model is compared on every
// falling edge, and literal expectations pin the key scenarios.
module tb_mem_arbiter;

  localparam logic [7:0] TO = 8'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_wen, lsu_req_ready, lsu_rsp_valid, lsu_rsp_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_addr(ifu_addr), .ifu_req_ready(ifu_req_ready),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_addr(lsu_addr), .lsu_wen(lsu_wen),
    .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_req_ready(lsu_req_ready),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a request is either absent, waiting for the memory to
  // take it, or waiting for the memory to answer; answers appear one cycle later.
  bit          m_busy, m_issued, m_owner_lsu, m_last_lsu;
  int          m_waited;
  logic [31:0] m_addr, m_wdata, m_ifu_d, m_lsu_d;
  logic        m_wen, m_ifu_v, m_ifu_e, m_lsu_v, m_lsu_e;
  logic [3:0]  m_wmask;
  logic        e_ifu_rdy, e_lsu_rdy;

  task automatic m_answer(input logic [31:0] data, input logic err);
    if (m_owner_lsu) begin
      m_lsu_v = 1'b1; m_lsu_d = data; m_lsu_e = err;
    end else begin
      m_ifu_v = 1'b1; m_ifu_d = data; m_ifu_e = err;
    end
    m_busy = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_busy = 0; m_issued = 0; m_owner_lsu = 0; m_last_lsu = 1; m_waited = 0;
        m_addr = 0; m_wdata = 0; m_wen = 0; m_wmask = 0;
        m_ifu_v = 0; m_ifu_d = 0; m_ifu_e = 0; m_lsu_v = 0; m_lsu_d = 0; m_lsu_e = 0;
      end
      e_ifu_rdy = rst && !m_busy && ifu_req_valid && (!lsu_req_valid || m_last_lsu);
      e_lsu_rdy = rst && !m_busy && lsu_req_valid && (!ifu_req_valid || !m_last_lsu);
      chk1("ifu_req_ready", ifu_req_ready, e_ifu_rdy);
      chk1("lsu_req_ready", lsu_req_ready, e_lsu_rdy);
      chk1("mem_req_valid", mem_req_valid, m_busy && m_issued);
      chk32("mem_addr", mem_addr, m_addr);
      chk1("mem_wen", mem_wen, m_wen);
      chk32("mem_wdata", mem_wdata, m_wdata);
      chk32("mem_wmask", 32'(mem_wmask), 32'(m_wmask));
      chk1("ifu_rsp_valid", ifu_rsp_valid, m_ifu_v);
      chk32("ifu_rdata", ifu_rdata, m_ifu_d);
      chk1("ifu_rsp_err", ifu_rsp_err, m_ifu_e);
      chk1("lsu_rsp_valid", lsu_rsp_valid, m_lsu_v);
      chk32("lsu_rdata", lsu_rdata, m_lsu_d);
      chk1("lsu_rsp_err", lsu_rsp_err, m_lsu_e);
      if (rst) begin
        m_ifu_v = 0; m_ifu_e = 0; m_lsu_v = 0; m_lsu_e = 0;
        if (!m_busy) begin
          if (e_ifu_rdy || e_lsu_rdy) begin
            m_busy = 1; m_issued = 1; m_owner_lsu = e_lsu_rdy; m_last_lsu = e_lsu_rdy;
            m_addr  = e_lsu_rdy ? lsu_addr : ifu_addr;
            m_wen   = e_lsu_rdy ? lsu_wen : 1'b0;
            m_wdata = e_lsu_rdy ? lsu_wdata : 32'h0;
            m_wmask = e_lsu_rdy ? lsu_wmask : 4'h0;
          end
        end else if (m_issued) begin
          if (mem_req_ready) begin
            m_issued = 0; m_waited = 0;
          end
        end else if (mem_rsp_valid) begin
          m_answer(mem_rdata, 1'b0);
        end else if (m_waited + 1 == int'(TO)) begin
          m_answer(32'h0, 1'b1);
        end else begin
          m_waited++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 0; ifu_req_valid = 0; ifu_addr = 0; lsu_req_valid = 0; lsu_addr = 0;
    lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0; mem_req_ready = 0; mem_rsp_valid = 0;
    mem_rdata = 0;
    step(); step();
    chk1("reset_mem_req_valid", mem_req_valid, 1'b0);
    chk32("reset_mem_addr", mem_addr, 32'h0);
    chk1("reset_ifu_rsp_valid", ifu_rsp_valid, 1'b0);
    rst = 1;
    step();

    // Single fetch, memory ready at once, answer one cycle into WAIT
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_req_ready = 1;
    step();
    chk32("fetch_mem_addr", mem_addr, 32'h8000_0000);
    chk1("fetch_mem_req_valid", mem_req_valid, 1'b1);
    ifu_req_valid = 0;
    step();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h0010_0073;
    step();
    chk1("fetch_rsp_valid", ifu_rsp_valid, 1'b1);
    chk32("fetch_rdata", ifu_rdata, 32'h0010_0073);
    chk1("fetch_rsp_err", ifu_rsp_err, 1'b0);
    mem_rsp_valid = 0;
    step();
    chk1("fetch_rsp_pulse_end", ifu_rsp_valid, 1'b0);

    // Tie after reset alternates IFU, LSU, IFU with back-to-back grants
    rst = 0; step(); rst = 1; step();
    ifu_addr = 32'h0000_1000; lsu_addr = 32'h0000_2000; lsu_wen = 0;
    ifu_req_valid = 1; lsu_req_valid = 1;
    mem_req_ready = 1; mem_rsp_valid = 1; mem_rdata = 32'h1111_0000;
    step();
    chk32("rr_grant0_ifu", mem_addr, 32'h0000_1000);
    step(); step(); step();
    chk32("rr_grant1_lsu", mem_addr, 32'h0000_2000);
    step(); step(); step();
    chk32("rr_grant2_ifu", mem_addr, 32'h0000_1000);
    ifu_req_valid = 0; lsu_req_valid = 0;
    step(); step();
    chk1("rr_last_rsp_valid", ifu_rsp_valid, 1'b1);
    chk32("rr_last_rdata", ifu_rdata, 32'h1111_0000);
    mem_req_ready = 0; mem_rsp_valid = 0;
    step();

    // Store held on the port while memory stalls
    lsu_addr = 32'h8000_0100; lsu_wen = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011;
    lsu_req_valid = 1;
    step();
    lsu_req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk1("store_hold_valid", mem_req_valid, 1'b1);
      chk32("store_hold_addr", mem_addr, 32'h8000_0100);
      chk32("store_hold_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk32("store_hold_wmask", 32'(mem_wmask), 32'h3);
      chk1("store_hold_wen", mem_wen, 1'b1);
      step();
    end
    mem_req_ready = 1;
    step();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h0000_00AA;
    step();
    chk1("store_rsp_valid", lsu_rsp_valid, 1'b1);
    chk32("store_rdata", lsu_rdata, 32'h0000_00AA);
    chk1("store_ifu_quiet", ifu_rsp_valid, 1'b0);
    mem_rsp_valid = 0;
    step();

    // Timeout: memory never answers
    ifu_addr = 32'h0000_3000; ifu_req_valid = 1; mem_req_ready = 1;
    step();
    ifu_req_valid = 0;
    step();
    mem_req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("timeout_no_early_rsp", ifu_rsp_valid, 1'b0);
    end
    step();
    chk1("timeout_rsp_valid", ifu_rsp_valid, 1'b1);
    chk32("timeout_rdata", ifu_rdata, 32'h0);
    chk1("timeout_rsp_err", ifu_rsp_err, 1'b1);
    mem_rsp_valid = 1; mem_rdata = 32'hFFFF_FFFF;
    step();
    chk1("late_rsp_ignored", ifu_rsp_valid, 1'b0);
    chk32("late_rsp_rdata_held", ifu_rdata, 32'h0);
    mem_rsp_valid = 0;
    step();

    // Response arriving in the last wait cycle beats the timeout
    lsu_addr = 32'h0000_4000; lsu_wen = 0; lsu_req_valid = 1; mem_req_ready = 1;
    step();
    lsu_req_valid = 0;
    step();
    mem_req_ready = 0;
    step(); step(); step();
    mem_rsp_valid = 1; mem_rdata = 32'h5555_AAAA;
    step();
    chk1("edge_rsp_valid", lsu_rsp_valid, 1'b1);
    chk1("edge_rsp_err", lsu_rsp_err, 1'b0);
    chk32("edge_rdata", lsu_rdata, 32'h5555_AAAA);
    mem_rsp_valid = 0;
    step();

    // Reset in WAIT drops the transaction silently
    ifu_addr = 32'h0000_5000; ifu_req_valid = 1; mem_req_ready = 1;
    step();
    ifu_req_valid = 0;
    step();
    mem_req_ready = 0;
    step();
    rst = 0;
    step();
    chk32("rst_lsu_rdata_cleared", lsu_rdata, 32'h0);
    rst = 1; mem_rsp_valid = 1; mem_rdata = 32'h0000_1234;
    step();
    chk1("rst_drop_ifu", ifu_rsp_valid, 1'b0);
    chk1("rst_drop_lsu", lsu_rsp_valid, 1'b0);
    chk1("rst_drop_mem_valid", mem_req_valid, 1'b0);
    mem_rsp_valid = 0;
    step();
    ifu_addr = 32'h0000_6000; lsu_addr = 32'h0000_7000;
    ifu_req_valid = 1; lsu_req_valid = 1;
    step();
    chk32("rst_tie_to_ifu", mem_addr, 32'h0000_6000);
    ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 1;
    step();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h0000_ABCD;
    step();
    chk1("rst_next_rsp_valid", ifu_rsp_valid, 1'b1);
    chk32("rst_next_rdata", ifu_rdata, 32'h0000_ABCD);
    mem_rsp_valid = 0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
